// File: rtl/load_buffer.sv
// rtl/load_buffer.sv - in-order load queue with single outstanding memory read and CDB broadcast
// Optional feature macro: LBUFFER_BYPASS_EN (same-edge issue for an enqueue into an empty idle buffer)

`ifndef LB
`define LB  6'd0
`endif
`ifndef LH
`define LH  6'd1
`endif
`ifndef LW
`define LW  6'd2
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif

module load_buffer #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             addrunit_lbuffer_en_in,
    input  logic [31:0]      addrunit_lbuffer_addr_in,
    input  logic [ROB_W-1:0] addrunit_lbuffer_dest_in,
    input  logic [OP_W-1:0]  addrunit_lbuffer_opcode_in,
    output logic             lbuffer_rs_rdy_out,
    output logic             lbuffer_mem_en_out,
    output logic [31:0]      lbuffer_mem_addr_out,
    output logic [1:0]       lbuffer_mem_size_out,
    input  logic             mem_lbuffer_rdy_in,
    input  logic             mem_lbuffer_valid_in,
    input  logic [31:0]      mem_lbuffer_data_in,
    input  logic             rob_lbuffer_rst_in,
    output logic [ROB_W-1:0] cdb_lbuffer_b_out,
    output logic [31:0]      cdb_lbuffer_result_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      addr_q [DEPTH];
    logic [ROB_W-1:0] dest_q [DEPTH];
    logic [OP_W-1:0]  op_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             live;
    logic             enq;
    logic             pop;
    logic             issue;
    logic             issue_bypass;
    logic             empty;
    logic             full;
    logic [31:0]      issue_addr;
    logic [OP_W-1:0]  issue_op;

    function automatic logic [1:0] size_of(input logic [OP_W-1:0] op);
        case (op)
            `LB, `LBU: size_of = 2'd0;
            `LH, `LHU: size_of = 2'd1;
            default:   size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [OP_W-1:0] op, input logic [31:0] d);
        case (op)
            `LB:     extend = {{24{d[7]}}, d[7:0]};
            `LH:     extend = {{16{d[15]}}, d[15:0]};
            `LBU:    extend = {24'd0, d[7:0]};
            `LHU:    extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // One slot of slack covers a request already in flight inside the address unit.
    assign lbuffer_rs_rdy_out = (count < CNT_W'(DEPTH - 1));

    // Per-edge decisions: enqueue, issue, pop and the next controller state.
    always_comb begin
        live = rdy_in && !rob_lbuffer_rst_in;
        enq  = live && addrunit_lbuffer_en_in && !full;
`ifdef LBUFFER_BYPASS_EN
        issue_bypass = live && (state == S_IDLE) && empty &&
                       addrunit_lbuffer_en_in && mem_lbuffer_rdy_in;
`else
        issue_bypass = 1'b0;
`endif
        issue = issue_bypass ||
                (live && (state == S_IDLE) && !empty && mem_lbuffer_rdy_in);
        pop   = live && (state == S_WAIT) && mem_lbuffer_valid_in;
        issue_addr = issue_bypass ? addrunit_lbuffer_addr_in   : addr_q[head];
        issue_op   = issue_bypass ? addrunit_lbuffer_opcode_in : op_q[head];

        state_next = state;
        if (rdy_in) begin
            if (rob_lbuffer_rst_in) begin
                // A flushed outstanding read still returns; DRAIN swallows it.
                if (state == S_WAIT) begin
                    state_next = S_DRAIN;
                end
            end else begin
                case (state)
                    S_IDLE:  if (issue)                state_next = S_WAIT;
                    S_WAIT:  if (mem_lbuffer_valid_in) state_next = S_IDLE;
                    S_DRAIN: if (mem_lbuffer_valid_in) state_next = S_IDLE;
                    default:                           state_next = S_IDLE;
                endcase
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry storage; written only on an accepted enqueue.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            addr_q[tail] <= addrunit_lbuffer_addr_in;
            dest_q[tail] <= addrunit_lbuffer_dest_in;
            op_q[tail]   <= addrunit_lbuffer_opcode_in;
        end
    end

    // Pointers, occupancy and registered memory/CDB outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head                   <= '0;
            tail                   <= '0;
            count                  <= '0;
            lbuffer_mem_en_out     <= 1'b0;
            lbuffer_mem_addr_out   <= 32'd0;
            lbuffer_mem_size_out   <= 2'd0;
            cdb_lbuffer_b_out      <= '0;
            cdb_lbuffer_result_out <= 32'd0;
        end else if (!rdy_in) begin
            lbuffer_mem_en_out <= 1'b0;
            cdb_lbuffer_b_out  <= '0;
        end else begin
            lbuffer_mem_en_out <= issue;
            cdb_lbuffer_b_out  <= pop ? dest_q[head] : '0;
            if (pop) begin
                cdb_lbuffer_result_out <= extend(op_q[head], mem_lbuffer_data_in);
            end
            if (issue) begin
                lbuffer_mem_addr_out <= issue_addr;
                lbuffer_mem_size_out <= size_of(issue_op);
            end
            if (rob_lbuffer_rst_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({enq, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of queue entries; power of two, at least 4.
REQ-002 Parameter ROB_W, default 4: ROB tag width; tag 0 means "no tag".
REQ-003 Parameter OP_W, default 6: opcode width; encodings come from the constant.vh macros LB, LH, LW, LBU, LHU.
REQ-004 Port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port rdy_in, input, 1 bit: global enable; when low, all state is frozen.
REQ-007 Port addrunit_lbuffer_en_in, input, 1 bit: a load request is presented this cycle.
REQ-008 Port addrunit_lbuffer_addr_in, input, 32 bits: effective byte address.
REQ-009 Port addrunit_lbuffer_dest_in, input, ROB_W bits: destination ROB tag.
REQ-010 Port addrunit_lbuffer_opcode_in, input, OP_W bits: load opcode.
REQ-011 Port lbuffer_rs_rdy_out, output, 1 bit: room exists for a new load.
REQ-012 Port lbuffer_mem_en_out, output, 1 bit: one-cycle read request pulse.
REQ-013 Port lbuffer_mem_addr_out, output, 32 bits: read address.
REQ-014 Port lbuffer_mem_size_out, output, 2 bits: read size; 0 = byte, 1 = half, 2 = word.
REQ-015 Port mem_lbuffer_rdy_in, input, 1 bit: memory controller can accept a request.
REQ-016 Port mem_lbuffer_valid_in, input, 1 bit: read data is valid this cycle.
REQ-017 Port mem_lbuffer_data_in, input, 32 bits: raw read data, right-aligned.
REQ-018 Port rob_lbuffer_rst_in, input, 1 bit: misprediction flush.
REQ-019 Port cdb_lbuffer_b_out, output, ROB_W bits: CDB broadcast tag; 0 means idle.
REQ-020 Port cdb_lbuffer_result_out, output, 32 bits: CDB broadcast value.

Function
REQ-021 The buffer SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a count of 0..DEPTH.
REQ-022 At an edge with addrunit_lbuffer_en_in=1, the buffer SHALL store {addr, dest, opcode} at tail, advance tail and increment count.
- A request arriving while count=DEPTH is a protocol violation and SHALL be dropped.
REQ-023 lbuffer_rs_rdy_out SHALL be combinational and equal (count < DEPTH-1), leaving one slot of slack for a request already in the address unit.
REQ-024 The controller SHALL use a three-state machine: IDLE, WAIT, DRAIN.
REQ-025 In IDLE with count>0 and mem_lbuffer_rdy_in=1, the next edge SHALL:
- drive lbuffer_mem_en_out=1 for one cycle;
- drive lbuffer_mem_addr_out and lbuffer_mem_size_out from the head entry;
- move the state to WAIT.
REQ-026 In WAIT, an edge with mem_lbuffer_valid_in=1 SHALL:
- drive cdb_lbuffer_b_out to the head entry's dest for exactly one cycle;
- drive cdb_lbuffer_result_out to the extended data;
- pop the head entry;
- return the state to IDLE.
REQ-027 Result extension SHALL be:
- LB: sign-extend bits [7:0];
- LH: sign-extend bits [15:0];
- LW: pass all 32 bits;
- LBU: zero-extend bits [7:0];
- LHU: zero-extend bits [15:0].
REQ-028 Size encoding SHALL be: LB/LBU = 0, LH/LHU = 1, LW = 2.
REQ-029 When an enqueue and a pop occur at the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-030 Loads SHALL complete strictly in FIFO order, with at most one memory request outstanding.
REQ-031 Minimum latency SHALL be: enqueue at edge N, request pulse after edge N+1, response at edge M, CDB tag valid after edge M.
REQ-032 A flush (rob_lbuffer_rst_in=1 at an edge) SHALL:
- empty the queue and zero both pointers and count;
- force cdb_lbuffer_b_out=0 and lbuffer_mem_en_out=0;
- drop any enqueue presented in the same cycle.
REQ-033 A flush taken in WAIT SHALL move the state to DRAIN rather than IDLE.
REQ-034 DRAIN SHALL discard the next mem_lbuffer_valid_in response with no CDB broadcast, then go to IDLE.
- DRAIN SHALL accept enqueues but SHALL NOT issue requests.
REQ-035 A flush taken in IDLE or DRAIN SHALL leave the state unchanged.
REQ-036 With rdy_in=0, all state SHALL hold, and lbuffer_mem_en_out and cdb_lbuffer_b_out SHALL read 0 at the next edge.
- The memory controller SHALL NOT assert mem_lbuffer_valid_in while rdy_in=0.

Reset
REQ-037 At an edge with rst_in=0, the block SHALL enter:
- state IDLE, count 0, head 0, tail 0;
- lbuffer_mem_en_out 0, lbuffer_mem_addr_out 0, lbuffer_mem_size_out 0;
- cdb_lbuffer_b_out 0, cdb_lbuffer_result_out 0.
REQ-038 Reset SHALL take priority over rdy_in and over flush.
REQ-039 After reset, lbuffer_rs_rdy_out SHALL read 1.
REQ-040 A reset during WAIT SHALL abandon the outstanding request; the memory controller is reset together with this block.

Configuration
REQ-041 With LBUFFER_BYPASS_EN defined, an enqueue into an empty buffer in IDLE with mem_lbuffer_rdy_in=1 SHALL:
- issue its request at the same edge, from the addrunit inputs;
- store the entry as the head;
- saving one cycle of latency.
REQ-042 With LBUFFER_BYPASS_EN undefined, every request SHALL be issued from a stored entry at least one edge after its enqueue.

Verification
REQ-043 Single LW, addr 0x100, dest 3, memory returns 0x12345678 two cycles after the request -> exactly one CDB cycle with tag 3 and value 0x12345678.
REQ-044 LB then LBU, both returning data 0x000000F0 -> results 0xFFFFFFF0 then 0x000000F0, broadcast in enqueue order.
REQ-045 Eight enqueues with memory held not ready -> lbuffer_rs_rdy_out falls after the 7th enqueue; tail wraps to 0; all eight complete in order after memory becomes ready.
REQ-046 Flush in WAIT, followed by a response, then a new LH with data 0x8001 -> the first response is dropped with no CDB cycle; the LH broadcasts 0xFFFF8001.
REQ-047 Enqueue and completion at the same edge with count=3 -> count stays 3.
REQ-048 rst_in=0 held mid-WAIT -> all outputs read 0 and lbuffer_rs_rdy_out reads 1 after the next edge.
